l2tlb_resp_stub: RTL and testbench
==================================

Name: l2tlb_resp_stub

Overview:
- Responder end of the L1-TLB-to-L2-TLB protocol: accepts `l1tlbtol2tlb_req` miss requests from an L1 TLB and returns ordered `l2tlbtol1tlb_ack` fills using identity translation after a programmable latency.
- Also initiates `l2tlbtol1tlb_snoop` invalidations on management request and collects the matching `l1tlbtol2tlb_sack`.
- Used as the L2 TLB model in passthrough builds and as a bench responder for L1 TLBs.

Parameters:
- FIFO_DEPTH, 4, request buffer entries (power of 2, >=2)
- ACK_LAT, 2, extra cycles an entry waits at FIFO head before its ack may assert (0..15)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- l1tlbtol2tlb_req_valid  in  1  request valid
- l1tlbtol2tlb_req_retry  out  1  request backpressure
- l1tlbtol2tlb_req_coreid  in  2  requesting core
- l1tlbtol2tlb_req_prefetch  in  1  prefetch flag, echoed
- l1tlbtol2tlb_req_laddr  in  39  virtual address
- l2tlbtol1tlb_ack_valid  out  1  fill valid
- l2tlbtol1tlb_ack_retry  in  1  fill backpressure
- l2tlbtol1tlb_ack_coreid  out  2  echoed coreid
- l2tlbtol1tlb_ack_prefetch  out  1  echoed prefetch
- l2tlbtol1tlb_ack_fault  out  1  translation fault
- l2tlbtol1tlb_ack_hpaadr  out  11  physical page bits [22:12]
- l2tlbtol1tlb_ack_ppaadr  out  3  physical page bits [14:12]
- inv_valid  in  1  management invalidate request
- inv_retry  out  1  invalidate backpressure
- inv_laddr  in  39  address to invalidate
- l2tlbtol1tlb_snoop_valid  out  1  snoop valid
- l2tlbtol1tlb_snoop_retry  in  1  snoop backpressure
- l2tlbtol1tlb_snoop_hpaadr  out  11  `inv_laddr[22:12]` captured
- l1tlbtol2tlb_sack_valid  in  1  snoop ack
- l1tlbtol2tlb_sack_retry  out  1  constant 0
- sack_err  out  1  sticky: sack received while no snoop outstanding

Behaviour:
- **Handshake (all channels).** Transfer occurs when valid=1 and retry=0 in the same cycle. The sender holds valid and payload stable while retry=1.
- **Reset (reset=0).** Asynchronous. FIFO empty, delay counter 0, FSM IDLE, `sack_err`=0. All valid outputs are 0 and all payload outputs are 0. `req_retry`=0 and `inv_retry`=0. Any in-flight snoop is dropped. The first legal transfer occurs in the first clk edge after release.
- **Request FIFO.**
  - `req_retry` = (count==FIFO_DEPTH), a registered full flag.
  - While full, no push is accepted even if a pop occurs in the same cycle.
  - Push and pop in the same cycle when not full keep count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- **Translation** is computed at push and stored per entry:
  - hpaadr = laddr[22:12]
  - ppaadr = laddr[14:12]
  - fault = |laddr[38:32]
  - coreid and prefetch are copied from the request.
  - Fault entries still produce acks, with fault=1 and hpaadr/ppaadr carrying the same bit-slices of laddr as normal.
- **Ack timing.**
  - A delay counter loads ACK_LAT whenever an entry becomes head: either a push into an empty FIFO or a pop with entries remaining. It decrements to 0 and saturates there.
  - `ack_valid` = FIFO non-empty and counter==0 and FSM not in SNOOP/WAIT_SACK.
  - Accept at cycle T into an empty FIFO gives `ack_valid` at T+1+ACK_LAT. A pop at P gives the next head valid at P+1+ACK_LAT.
  - Acks are strictly in request order. Payload is driven from the head entry and is 0 when `ack_valid`=0.
- **Ack pop.** A pop occurs on an ack transfer. While `ack_retry`=1 the head, payload and counter are held.
- **Invalidate FSM.**
  - IDLE: `inv_retry`=0. On `inv_valid`, capture hpaadr and go to SNOOP.
  - SNOOP: `snoop_valid`=1. On transfer go to WAIT_SACK.
  - WAIT_SACK: on `sack_valid` go to IDLE.
  - `inv_retry`=1 in SNOOP and WAIT_SACK.
  - `ack_valid` is forced 0 in SNOOP and WAIT_SACK, which blocks fills racing an invalidation. The counter keeps running, so the ack resumes the cycle after return to IDLE if the counter is 0.
  - Requests are still accepted during SNOOP/WAIT_SACK.
- **Sack handling.**
  - A sack in IDLE or SNOOP is consumed, sets `sack_err`, and does not change FSM state.
  - `sack_err` clears only on reset.
- **Simultaneous inv_valid and ack eligibility in IDLE.** The ack presented that cycle (`ack_valid`=1) may transfer. `ack_valid` drops from the next cycle.

Test Plan:
1. **Single request.** ACK_LAT=2, accept laddr=0x00_1234_5678, coreid=1, prefetch=0 at cycle 10 -> `ack_valid` at cycle 13 with hpaadr=0x345, ppaadr=0x5, fault=0, coreid=1.
2. **Full FIFO.** 5 back-to-back requests with `ack_retry`=1 held -> 4 accepted, `req_retry`=1 from the cycle after the 4th. Release retry -> acks in order, one per 3 cycles, and `req_retry` drops after the first pop.
3. **Fault request.** laddr=0x40_0000_1000 -> ack with fault=1, hpaadr=0x001, ppaadr=0x1.
4. **Invalidate with queued requests.** inv_laddr=0x00_0000_3000 with 2 requests queued -> `snoop_valid` with hpaadr=0x003, held 3 cycles under `snoop_retry`. Acks stay 0 until 1 cycle after `sack_valid`, then resume in order.
5. **Unexpected sack and reset.** `sack_valid` while IDLE -> `sack_err`=1 stays set. Assert reset mid-snoop with 3 queued -> all outputs 0 immediately. After release, a new request is acked with no stale entries.
6. **Zero latency.** ACK_LAT=0, accept at T -> `ack_valid` at T+1. Push into an empty FIFO concurrent with an ack pop of the last entry -> new head valid one cycle later.

Source files
------------

// File: rtl/l2tlb_resp_stub_if.sv
// L1-TLB <-> L2-TLB channel bundle for l2tlb_resp_stub.
// Channels: req (L1 -> L2 miss), ack (L2 -> L1 fill), inv (management -> stub),
// snoop (L2 -> L1 invalidate), sack (L1 -> L2 snoop ack), plus sticky sack_err.
// slave modport is the responder (stub) side, master is the L1/management side.
interface l2tlb_resp_stub_if;
    logic        l1tlbtol2tlb_req_valid;
    logic        l1tlbtol2tlb_req_retry;
    logic [1:0]  l1tlbtol2tlb_req_coreid;
    logic        l1tlbtol2tlb_req_prefetch;
    logic [38:0] l1tlbtol2tlb_req_laddr;

    logic        l2tlbtol1tlb_ack_valid;
    logic        l2tlbtol1tlb_ack_retry;
    logic [1:0]  l2tlbtol1tlb_ack_coreid;
    logic        l2tlbtol1tlb_ack_prefetch;
    logic        l2tlbtol1tlb_ack_fault;
    logic [10:0] l2tlbtol1tlb_ack_hpaadr;
    logic [2:0]  l2tlbtol1tlb_ack_ppaadr;

    logic        inv_valid;
    logic        inv_retry;
    logic [38:0] inv_laddr;

    logic        l2tlbtol1tlb_snoop_valid;
    logic        l2tlbtol1tlb_snoop_retry;
    logic [10:0] l2tlbtol1tlb_snoop_hpaadr;

    logic        l1tlbtol2tlb_sack_valid;
    logic        l1tlbtol2tlb_sack_retry;
    logic        sack_err;

    modport slave (
        input  l1tlbtol2tlb_req_valid, l1tlbtol2tlb_req_coreid,
               l1tlbtol2tlb_req_prefetch, l1tlbtol2tlb_req_laddr,
               l2tlbtol1tlb_ack_retry, inv_valid, inv_laddr,
               l2tlbtol1tlb_snoop_retry, l1tlbtol2tlb_sack_valid,
        output l1tlbtol2tlb_req_retry, l2tlbtol1tlb_ack_valid,
               l2tlbtol1tlb_ack_coreid, l2tlbtol1tlb_ack_prefetch,
               l2tlbtol1tlb_ack_fault, l2tlbtol1tlb_ack_hpaadr,
               l2tlbtol1tlb_ack_ppaadr, inv_retry, l2tlbtol1tlb_snoop_valid,
               l2tlbtol1tlb_snoop_hpaadr, l1tlbtol2tlb_sack_retry, sack_err
    );

    modport master (
        output l1tlbtol2tlb_req_valid, l1tlbtol2tlb_req_coreid,
               l1tlbtol2tlb_req_prefetch, l1tlbtol2tlb_req_laddr,
               l2tlbtol1tlb_ack_retry, inv_valid, inv_laddr,
               l2tlbtol1tlb_snoop_retry, l1tlbtol2tlb_sack_valid,
        input  l1tlbtol2tlb_req_retry, l2tlbtol1tlb_ack_valid,
               l2tlbtol1tlb_ack_coreid, l2tlbtol1tlb_ack_prefetch,
               l2tlbtol1tlb_ack_fault, l2tlbtol1tlb_ack_hpaadr,
               l2tlbtol1tlb_ack_ppaadr, inv_retry, l2tlbtol1tlb_snoop_valid,
               l2tlbtol1tlb_snoop_hpaadr, l1tlbtol2tlb_sack_retry, sack_err
    );
endinterface

// File: rtl/l2tlb_resp_stub.sv
// L2 TLB responder stub: buffers L1 TLB miss requests and returns in-order
// identity-translation fills after ACK_LAT cycles at the FIFO head; issues
// snoop invalidations on management request and collects the snoop ack.
// Ports: clk, reset (async active-low), bus (l2tlb_resp_stub_if.slave).
module l2tlb_resp_stub #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ACK_LAT    = 2
) (
    input  logic             clk,
    input  logic             reset,
    l2tlb_resp_stub_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned LAT_W = 4;

    typedef struct packed {
        logic [1:0]  coreid;
        logic        prefetch;
        logic        fault;
        logic [10:0] hpaadr;
        logic [2:0]  ppaadr;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SNOOP     = 2'd1,
        WAIT_SACK = 2'd2
    } state_t;

    entry_t           mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr, rd_ptr_d, wr_ptr, wr_ptr_d;
    logic [CNT_W-1:0] count, count_d;
    logic [LAT_W-1:0] lat_cnt, lat_cnt_d;
    state_t           state, state_d;

    logic        req_retry_q, req_retry_d;
    logic        ack_valid_q, ack_valid_d;
    entry_t      ack_q, ack_d;
    logic        inv_retry_q, inv_retry_d;
    logic        snoop_valid_q, snoop_valid_d;
    logic [10:0] snoop_hpa_q, snoop_hpa_d;
    logic        sack_err_q, sack_err_d;

    logic   push, pop;
    entry_t new_entry, head_d;

    // Address bits that carry no translation information.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.l1tlbtol2tlb_req_laddr[31:23], bus.l1tlbtol2tlb_req_laddr[11:0],
                                bus.inv_laddr[38:23], bus.inv_laddr[11:0]};

    // Next-state and registered-output computation.
    always_comb begin
        push = bus.l1tlbtol2tlb_req_valid && !req_retry_q;
        pop  = ack_valid_q && !bus.l2tlbtol1tlb_ack_retry;

        new_entry.coreid   = bus.l1tlbtol2tlb_req_coreid;
        new_entry.prefetch = bus.l1tlbtol2tlb_req_prefetch;
        new_entry.fault    = |bus.l1tlbtol2tlb_req_laddr[38:32];
        new_entry.hpaadr   = bus.l1tlbtol2tlb_req_laddr[22:12];
        new_entry.ppaadr   = bus.l1tlbtol2tlb_req_laddr[14:12];

        wr_ptr_d = push ? wr_ptr + PTR_W'(1) : wr_ptr;
        rd_ptr_d = pop  ? rd_ptr + PTR_W'(1) : rd_ptr;
        count_d  = count + CNT_W'(push) - CNT_W'(pop);

        // Reload whenever a new entry reaches the head, else count down to 0.
        lat_cnt_d = lat_cnt;
        if ((push && count == '0) || (pop && count_d != '0)) begin
            lat_cnt_d = LAT_W'(ACK_LAT);
        end else if (lat_cnt != '0) begin
            lat_cnt_d = lat_cnt - LAT_W'(1);
        end

        state_d     = state;
        snoop_hpa_d = snoop_hpa_q;
        sack_err_d  = sack_err_q;
        case (state)
            IDLE: begin
                if (bus.inv_valid) begin
                    state_d     = SNOOP;
                    snoop_hpa_d = bus.inv_laddr[22:12];
                end
            end
            SNOOP: begin
                if (!bus.l2tlbtol1tlb_snoop_retry) state_d = WAIT_SACK;
            end
            WAIT_SACK: begin
                if (bus.l1tlbtol2tlb_sack_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (bus.l1tlbtol2tlb_sack_valid && state != WAIT_SACK) sack_err_d = 1'b1;

        // The head after this edge may be the entry being written right now.
        head_d = (push && rd_ptr_d == wr_ptr) ? new_entry : mem[rd_ptr_d];

        req_retry_d   = (count_d == CNT_W'(FIFO_DEPTH));
        ack_valid_d   = (count_d != '0) && (lat_cnt_d == '0) && (state_d == IDLE);
        ack_d         = ack_valid_d ? head_d : '0;
        inv_retry_d   = (state_d != IDLE);
        snoop_valid_d = (state_d == SNOOP);
        if (state_d != SNOOP) snoop_hpa_d = '0;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            lat_cnt       <= '0;
            state         <= IDLE;
            req_retry_q   <= 1'b0;
            ack_valid_q   <= 1'b0;
            ack_q         <= '0;
            inv_retry_q   <= 1'b0;
            snoop_valid_q <= 1'b0;
            snoop_hpa_q   <= '0;
            sack_err_q    <= 1'b0;
        end else begin
            rd_ptr        <= rd_ptr_d;
            wr_ptr        <= wr_ptr_d;
            count         <= count_d;
            lat_cnt       <= lat_cnt_d;
            state         <= state_d;
            req_retry_q   <= req_retry_d;
            ack_valid_q   <= ack_valid_d;
            ack_q         <= ack_d;
            inv_retry_q   <= inv_retry_d;
            snoop_valid_q <= snoop_valid_d;
            snoop_hpa_q   <= snoop_hpa_d;
            sack_err_q    <= sack_err_d;
        end
    end

    // Entry storage; contents only matter while counted valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= new_entry;
    end

    assign bus.l1tlbtol2tlb_req_retry    = req_retry_q;
    assign bus.l2tlbtol1tlb_ack_valid    = ack_valid_q;
    assign bus.l2tlbtol1tlb_ack_coreid   = ack_q.coreid;
    assign bus.l2tlbtol1tlb_ack_prefetch = ack_q.prefetch;
    assign bus.l2tlbtol1tlb_ack_fault    = ack_q.fault;
    assign bus.l2tlbtol1tlb_ack_hpaadr   = ack_q.hpaadr;
    assign bus.l2tlbtol1tlb_ack_ppaadr   = ack_q.ppaadr;
    assign bus.inv_retry                 = inv_retry_q;
    assign bus.l2tlbtol1tlb_snoop_valid  = snoop_valid_q;
    assign bus.l2tlbtol1tlb_snoop_hpaadr = snoop_hpa_q;
    assign bus.l1tlbtol2tlb_sack_retry   = 1'b0;
    assign bus.sack_err                  = sack_err_q;
endmodule

// File: tb/tb_l2tlb_resp_stub.sv
// Self-checking bench for l2tlb_resp_stub: scoreboard of expected fills
// pushed on request accept and popped on ack transfer, plus directed timing
// checks. A second instance with ACK_LAT=0 covers zero-latency behaviour.
module tb_l2tlb_resp_stub;
    logic clk;
    logic reset;
    int   cyc;
    int   n_cmp;
    int   n_err;

    logic [17:0] exp_q [$];
    int          ack_cyc_q [$];
    logic [17:0] mon_exp;

    l2tlb_resp_stub_if bus ();
    l2tlb_resp_stub_if bus_z ();

    l2tlb_resp_stub #(.FIFO_DEPTH(4), .ACK_LAT(2)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    l2tlb_resp_stub #(.FIFO_DEPTH(4), .ACK_LAT(0)) u_dut_z (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_z)
    );

    logic [17:0] ack_w, ack_z_w;
    assign ack_w   = {bus.l2tlbtol1tlb_ack_coreid, bus.l2tlbtol1tlb_ack_prefetch,
                      bus.l2tlbtol1tlb_ack_fault, bus.l2tlbtol1tlb_ack_hpaadr,
                      bus.l2tlbtol1tlb_ack_ppaadr};
    assign ack_z_w = {bus_z.l2tlbtol1tlb_ack_coreid, bus_z.l2tlbtol1tlb_ack_prefetch,
                      bus_z.l2tlbtol1tlb_ack_fault, bus_z.l2tlbtol1tlb_ack_hpaadr,
                      bus_z.l2tlbtol1tlb_ack_ppaadr};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required < 300000", $time);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [17:0] exp_of(input logic [1:0] c, input logic p, input logic [38:0] a);
        return {c, p, |a[38:32], a[22:12], a[14:12]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for the pending request on bus to be accepted; at = accept cycle.
    task automatic wait_accept(output int at);
        at = -1;
        for (int i = 0; i < 64; i++) begin
            if (!bus.l1tlbtol2tlb_req_retry) begin
                at = cyc;
                step();
                bus.l1tlbtol2tlb_req_valid = 1'b0;
                return;
            end
            step();
        end
        bus.l1tlbtol2tlb_req_valid = 1'b0;
        check_eq("req_accept_timeout", 64'(bus.l1tlbtol2tlb_req_retry), 64'd0);
    endtask

    task automatic send_req(input logic [1:0] c, input logic p, input logic [38:0] a, output int at);
        bus.l1tlbtol2tlb_req_valid    = 1'b1;
        bus.l1tlbtol2tlb_req_coreid   = c;
        bus.l1tlbtol2tlb_req_prefetch = p;
        bus.l1tlbtol2tlb_req_laddr    = a;
        wait_accept(at);
    endtask

    task automatic wait_ack_valid(input string tag, output int at);
        at = -1;
        for (int i = 0; i < 40; i++) begin
            if (bus.l2tlbtol1tlb_ack_valid) begin
                at = cyc;
                return;
            end
            step();
        end
        check_eq(tag, 64'(bus.l2tlbtol1tlb_ack_valid), 64'd1);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0) return;
            step();
        end
        check_eq(tag, 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard monitor: pop/compare on ack transfer, push on request accept.
    always @(negedge clk) begin
        if (reset) begin
            if (bus.l2tlbtol1tlb_ack_valid && !bus.l2tlbtol1tlb_ack_retry) begin
                ack_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check_eq("ack_unexpected", 64'(exp_q.size()), 64'd1);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check_eq("ack_payload", 64'(ack_w), 64'(mon_exp));
                end
            end else if (!bus.l2tlbtol1tlb_ack_valid) begin
                check_eq("ack_idle_zero", 64'(ack_w), 64'd0);
            end
            if (bus.l1tlbtol2tlb_req_valid && !bus.l1tlbtol2tlb_req_retry)
                exp_q.push_back(exp_of(bus.l1tlbtol2tlb_req_coreid,
                                       bus.l1tlbtol2tlb_req_prefetch,
                                       bus.l1tlbtol2tlb_req_laddr));
        end
    end

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_outs"},
                 64'({bus.l1tlbtol2tlb_req_retry, bus.l2tlbtol1tlb_ack_valid, bus.inv_retry,
                      bus.l2tlbtol1tlb_snoop_valid, bus.l2tlbtol1tlb_snoop_hpaadr,
                      bus.sack_err, bus.l1tlbtol2tlb_sack_retry}), 64'd0);
        check_eq({tag, "_ack_payload"}, 64'(ack_w), 64'd0);
    endtask

    initial begin
        int acc [5];
        int t, x, ii;
        logic [38:0] a;

        cyc   = 0;
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        bus.l1tlbtol2tlb_req_valid      = 1'b0;
        bus.l1tlbtol2tlb_req_coreid     = '0;
        bus.l1tlbtol2tlb_req_prefetch   = 1'b0;
        bus.l1tlbtol2tlb_req_laddr      = '0;
        bus.l2tlbtol1tlb_ack_retry      = 1'b0;
        bus.inv_valid                   = 1'b0;
        bus.inv_laddr                   = '0;
        bus.l2tlbtol1tlb_snoop_retry    = 1'b0;
        bus.l1tlbtol2tlb_sack_valid     = 1'b0;
        bus_z.l1tlbtol2tlb_req_valid    = 1'b0;
        bus_z.l1tlbtol2tlb_req_coreid   = '0;
        bus_z.l1tlbtol2tlb_req_prefetch = 1'b0;
        bus_z.l1tlbtol2tlb_req_laddr    = '0;
        bus_z.l2tlbtol1tlb_ack_retry    = 1'b0;
        bus_z.inv_valid                 = 1'b0;
        bus_z.inv_laddr                 = '0;
        bus_z.l2tlbtol1tlb_snoop_retry  = 1'b0;
        bus_z.l1tlbtol2tlb_sack_valid   = 1'b0;

        step();
        step();
        check_all_zero("reset");
        reset = 1'b1;
        repeat (7) step();

        // 1: single request, ACK_LAT=2
        send_req(2'd1, 1'b0, 39'h00_1234_5678, t);
        wait_ack_valid("t1_ack_timeout", x);
        check_eq("t1_latency", 64'(x), 64'(t + 3));
        check_eq("t1_hpaadr", 64'(bus.l2tlbtol1tlb_ack_hpaadr), 64'h345);
        check_eq("t1_ppaadr", 64'(bus.l2tlbtol1tlb_ack_ppaadr), 64'h5);
        check_eq("t1_fault", 64'(bus.l2tlbtol1tlb_ack_fault), 64'd0);
        check_eq("t1_coreid", 64'(bus.l2tlbtol1tlb_ack_coreid), 64'd1);
        wait_drain("t1_drain");

        // 2: full FIFO with ack backpressure, then release
        bus.l2tlbtol1tlb_ack_retry = 1'b1;
        step();
        ack_cyc_q.delete();
        for (int i = 0; i < 4; i++) begin
            a = 39'h00_0012_3000 + 39'(i) * 39'h1000;
            if (i == 3) a[33] = 1'b1;
            send_req(2'(i), i[0], a, acc[i]);
        end
        check_eq("t2_back_to_back", 64'(acc[3]), 64'(acc[0] + 3));
        check_eq("t2_full", 64'(bus.l1tlbtol2tlb_req_retry), 64'd1);
        bus.l1tlbtol2tlb_req_valid    = 1'b1;
        bus.l1tlbtol2tlb_req_coreid   = 2'd2;
        bus.l1tlbtol2tlb_req_prefetch = 1'b1;
        bus.l1tlbtol2tlb_req_laddr    = 39'h00_0077_7000;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("t2_full_hold", 64'(bus.l1tlbtol2tlb_req_retry), 64'd1);
        end
        x = cyc;
        bus.l2tlbtol1tlb_ack_retry = 1'b0;
        wait_accept(acc[4]);
        check_eq("t2_fifth_accept", 64'(acc[4]), 64'(x + 1));
        wait_drain("t2_drain");
        check_eq("t2_ack_count", 64'(ack_cyc_q.size()), 64'd5);
        if (ack_cyc_q.size() == 5) begin
            check_eq("t2_first_pop", 64'(ack_cyc_q[0]), 64'(x));
            for (int i = 1; i < 5; i++)
                check_eq("t2_ack_spacing", 64'(ack_cyc_q[i] - ack_cyc_q[i-1]), 64'd3);
        end

        // 3: fault request
        send_req(2'd3, 1'b1, 39'h40_0000_1000, t);
        wait_ack_valid("t3_ack_timeout", x);
        check_eq("t3_fault", 64'(bus.l2tlbtol1tlb_ack_fault), 64'd1);
        check_eq("t3_hpaadr", 64'(bus.l2tlbtol1tlb_ack_hpaadr), 64'h001);
        check_eq("t3_ppaadr", 64'(bus.l2tlbtol1tlb_ack_ppaadr), 64'h1);
        wait_drain("t3_drain");

        // 4: invalidate with queued requests; ack and inv coincide in IDLE
        bus.l2tlbtol1tlb_ack_retry = 1'b1;
        for (int i = 0; i < 3; i++) send_req(2'(i + 1), 1'b0, 39'h00_0040_0000 + 39'(i) * 39'h2000, t);
        wait_ack_valid("t4_head_timeout", x);
        ack_cyc_q.delete();
        bus.inv_valid                = 1'b1;
        bus.inv_laddr                = 39'h00_0000_3000;
        bus.l2tlbtol1tlb_snoop_retry = 1'b1;
        bus.l2tlbtol1tlb_ack_retry   = 1'b0;
        check_eq("t4_inv_ready", 64'(bus.inv_retry), 64'd0);
        ii = cyc;
        step();
        bus.inv_valid = 1'b0;
        check_eq("t4_race_ack_count", 64'(ack_cyc_q.size()), 64'd1);
        if (ack_cyc_q.size() == 1) check_eq("t4_race_ack_cycle", 64'(ack_cyc_q[0]), 64'(ii));
        for (int i = 0; i < 3; i++) begin
            check_eq("t4_snoop_valid", 64'(bus.l2tlbtol1tlb_snoop_valid), 64'd1);
            check_eq("t4_snoop_hpaadr", 64'(bus.l2tlbtol1tlb_snoop_hpaadr), 64'h003);
            check_eq("t4_ack_blocked", 64'(bus.l2tlbtol1tlb_ack_valid), 64'd0);
            check_eq("t4_inv_busy", 64'(bus.inv_retry), 64'd1);
            step();
        end
        bus.l2tlbtol1tlb_snoop_retry = 1'b0;
        check_eq("t4_snoop_valid_last", 64'(bus.l2tlbtol1tlb_snoop_valid), 64'd1);
        step();
        check_eq("t4_snoop_done", 64'(bus.l2tlbtol1tlb_snoop_valid), 64'd0);
        check_eq("t4_snoop_hpa_clear", 64'(bus.l2tlbtol1tlb_snoop_hpaadr), 64'd0);
        check_eq("t4_wait_ack_blocked", 64'(bus.l2tlbtol1tlb_ack_valid), 64'd0);
        check_eq("t4_wait_inv_busy", 64'(bus.inv_retry), 64'd1);
        step();
        check_eq("t4_wait_ack_blocked2", 64'(bus.l2tlbtol1tlb_ack_valid), 64'd0);
        bus.l1tlbtol2tlb_sack_valid = 1'b1;
        step();
        bus.l1tlbtol2tlb_sack_valid = 1'b0;
        check_eq("t4_ack_resume", 64'(bus.l2tlbtol1tlb_ack_valid), 64'd1);
        check_eq("t4_inv_free", 64'(bus.inv_retry), 64'd0);
        check_eq("t4_no_sack_err", 64'(bus.sack_err), 64'd0);
        wait_drain("t4_drain");
        check_eq("t4_ack_total", 64'(ack_cyc_q.size()), 64'd3);

        // 5: unexpected sack, then reset in the middle of a snoop
        bus.l1tlbtol2tlb_sack_valid = 1'b1;
        step();
        bus.l1tlbtol2tlb_sack_valid = 1'b0;
        check_eq("t5_sack_err_set", 64'(bus.sack_err), 64'd1);
        check_eq("t5_state_idle", 64'(bus.inv_retry), 64'd0);
        repeat (3) step();
        check_eq("t5_sack_err_sticky", 64'(bus.sack_err), 64'd1);
        bus.l2tlbtol1tlb_ack_retry = 1'b1;
        for (int i = 0; i < 3; i++) send_req(2'(i), 1'b1, 39'h00_0100_0000 + 39'(i) * 39'h1000, t);
        bus.inv_valid                = 1'b1;
        bus.inv_laddr                = 39'h00_0055_5000;
        bus.l2tlbtol1tlb_snoop_retry = 1'b1;
        step();
        bus.inv_valid = 1'b0;
        check_eq("t5_in_snoop", 64'(bus.l2tlbtol1tlb_snoop_valid), 64'd1);
        step();
        #2;
        reset = 1'b0;
        exp_q.delete();
        #1;
        check_all_zero("t5_reset");
        step();
        step();
        bus.l2tlbtol1tlb_snoop_retry = 1'b0;
        bus.l2tlbtol1tlb_ack_retry   = 1'b0;
        reset = 1'b1;
        #1;
        check_all_zero("t5_release");
        step();
        ack_cyc_q.delete();
        send_req(2'd2, 1'b0, 39'h00_0abc_d000, t);
        wait_ack_valid("t5_ack_timeout", x);
        check_eq("t5_latency", 64'(x), 64'(t + 3));
        wait_drain("t5_drain");
        repeat (6) step();
        check_eq("t5_no_stale", 64'(bus.l2tlbtol1tlb_ack_valid), 64'd0);
        check_eq("t5_ack_total", 64'(ack_cyc_q.size()), 64'd1);

        // 6: zero latency instance; push into emptying FIFO during last pop
        bus_z.l1tlbtol2tlb_req_valid    = 1'b1;
        bus_z.l1tlbtol2tlb_req_coreid   = 2'd2;
        bus_z.l1tlbtol2tlb_req_prefetch = 1'b1;
        bus_z.l1tlbtol2tlb_req_laddr    = 39'h00_0000_7000;
        check_eq("t6_ready", 64'(bus_z.l1tlbtol2tlb_req_retry), 64'd0);
        check_eq("t6_idle", 64'(bus_z.l2tlbtol1tlb_ack_valid), 64'd0);
        step();
        check_eq("t6_ack_next_cycle", 64'(bus_z.l2tlbtol1tlb_ack_valid), 64'd1);
        check_eq("t6_payload0", 64'(ack_z_w), 64'(exp_of(2'd2, 1'b1, 39'h00_0000_7000)));
        bus_z.l1tlbtol2tlb_req_coreid   = 2'd3;
        bus_z.l1tlbtol2tlb_req_prefetch = 1'b0;
        bus_z.l1tlbtol2tlb_req_laddr    = 39'h01_0065_4000;
        step();
        bus_z.l1tlbtol2tlb_req_valid = 1'b0;
        check_eq("t6_bypass_valid", 64'(bus_z.l2tlbtol1tlb_ack_valid), 64'd1);
        check_eq("t6_payload1", 64'(ack_z_w), 64'(exp_of(2'd3, 1'b0, 39'h01_0065_4000)));
        step();
        check_eq("t6_empty", 64'(bus_z.l2tlbtol1tlb_ack_valid), 64'd0);
        check_eq("t6_empty_payload", 64'(ack_z_w), 64'd0);

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
